// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the write-back stage and
// the architectural register file.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // Index of the hardwired-zero register ($zero).
  localparam reg_idx_t REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/wb_regfile_read_port.sv
// One combinational register-file read port for the ID stage.
// Looks up the addressed register and forces $zero to read 0.
// Optional macro WB_BYPASS_EN: when defined, a write committing this cycle
// to the addressed nonzero register is forwarded straight to the output
// (write-before-read). When undefined, the stored pre-write value is returned.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0] rd_idx_i,
`ifdef WB_BYPASS_EN
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  output logic [DATA_W-1:0] rd_data_o
);
  import mips_pkg::*;

  logic rd_is_zero;

  assign rd_is_zero = (rd_idx_i == ADDR_W'(REG_ZERO));

  // Select stored value, zero register, or (optionally) the in-flight write.
  always_comb begin
    rd_data_o = regs_i[rd_idx_i];
`ifdef WB_BYPASS_EN
    // wr_en_i already excludes writes to $zero, so no extra guard is needed
    // here; the zero forcing below wins regardless.
    if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
    if (rd_is_zero) begin
      rd_data_o = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file of the 5-stage MIPS
// pipeline. Selects the write-back value from MEM/WB, commits it to the
// register file, counts committed writes and serves two read ports to ID.
// Optional macro WB_BYPASS_EN enables same-cycle write-to-read forwarding
// inside the read ports; without it ID must stall one cycle on that hazard.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic [CNT_W-1:0]  wbCount
);
  import mips_pkg::*;

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              wr_en;

  // Write-back mux: load data or ALU result, independent of RegWrite so the
  // EX stage can forward it whenever MEM/WB holds a valid instruction.
  assign wbData = MemtoReg ? readData : ALUresult;

  // Writes to $zero are dropped entirely: no state change and no count.
  // With RegWrite low the AND masks any unknown writeReg.
  assign wr_en = RegWrite && (writeReg != ADDR_W'(REG_ZERO));

  // Next-state of the register array and committed-write counter.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      regs_d[writeReg] = wbData;
      cnt_d            = cnt_q + 1'b1;
    end
  end

  // Register array and counter; asynchronous clear, commit on posedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wbCount = cnt_q;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .regs_i    (regs_q),
    .rd_idx_i  (readReg1),
`ifdef WB_BYPASS_EN
    .wr_en_i   (wr_en),
    .wr_idx_i  (writeReg),
    .wr_data_i (wbData),
`endif
    .rd_data_o (readData1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .regs_i    (regs_q),
    .rd_idx_i  (readReg2),
`ifdef WB_BYPASS_EN
    .wr_en_i   (wr_en),
    .wr_idx_i  (writeReg),
    .wr_data_i (wbData),
`endif
    .rd_data_o (readData2)
  );

endmodule : wb_regfile
